// File: rtl/dmem_access_ctrl.sv
// Multicycle data-memory access controller for the MEM stage.
// It accepts one load or store request, checks that the request is legal,
// runs a single req/ack transaction to data memory and then reports a
// one-cycle done pulse, with err set if the request failed.
// Store data is replicated onto the byte lanes the byte enables select.
// Load data is extracted from the returned word and sign- or zero-extended.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TCW     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_type,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  logic [1:0]     state;
  logic [TCW-1:0] tmo_cnt;
  logic [1:0]     addr_lo;
  logic [2:0]     ld_q;

  logic           req_legal;
  logic [31:0]    repl_wdata;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_ext;

  assign busy    = (state != S_IDLE);
  assign mem_req = (state == S_ACCESS);

  // Legality of the incoming request: store byte-enable shape, load alignment.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    req_legal = 1'b0;
    if (we) begin
      case (be)
        4'b1111, 4'b1100, 4'b0011,
        4'b0001, 4'b0010, 4'b0100, 4'b1000: req_legal = 1'b1;
        default:                            req_legal = 1'b0;
      endcase
    end else begin
      case (ld_type)
        LD_LH, LD_LHU: req_legal = ~addr[0];
        LD_LB, LD_LBU: req_legal = 1'b1;
        default:       req_legal = (addr[1:0] == 2'b00);
      endcase
    end
  end

  // Replicate store data onto the lanes implied by the byte-enable shape.
  always_comb begin
    repl_wdata = wdata;
    case (be)
      4'b1100, 4'b0011:
        repl_wdata = {wdata[15:0], wdata[15:0]};
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        repl_wdata = {4{wdata[7:0]}};
      default:
        repl_wdata = wdata;
    endcase
  end

  // Extract and extend the addressed byte/halfword from the returned word.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_lo)
      2'b00: ld_byte = mem_rdata[7:0];
      2'b01: ld_byte = mem_rdata[15:8];
      2'b10: ld_byte = mem_rdata[23:16];
      2'b11: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_q)
      LD_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_ext = {16'h0000, ld_half};
      LD_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_ext = {24'h000000, ld_byte};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Transaction FSM plus the request, response and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so every output is defined straight out of reset.
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      addr_lo   <= 2'b00;
      ld_q      <= 3'b000;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_we    <= we;
            mem_addr  <= addr[31:2];
            addr_lo   <= addr[1:0];
            mem_be    <= we ? be : 4'hF;
            mem_wdata <= repl_wdata;
            ld_q      <= ld_type;
            tmo_cnt   <= '0;
            if (req_legal) begin
              state <= S_ACCESS;
            end else begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) rdata <= ld_ext;
            state <= S_RESP;
            done  <= 1'b1;
            err   <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_RESP;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          done    <= 1'b0;
          err     <= 1'b0;
          tmo_cnt <= '0;
          state   <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: stores, loads, illegal requests,
// timeout, ack on the last timeout cycle and mid-transaction reset.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  ld_type;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles;

  dmem_access_ctrl #(.TIMEOUT(16), .TCW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .we        (we),
    .addr      (addr),
    .be        (be),
    .wdata     (wdata),
    .ld_type   (ld_type),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present a request for one clock edge; returns #1 after that edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [2:0] lt);
    we = w; addr = a; be = b; wdata = d; ld_type = lt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Hold mem_ack high for one cycle with the given read word.
  task automatic ack_cycle(input logic [31:0] rd);
    mem_rdata = rd; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    ld_type = '0; mem_rdata = '0; mem_ack = 1'b0;
    #2;
    check("rst_busy",    {31'b0, busy},    32'd0);
    check("rst_done",    {31'b0, done},    32'd0);
    check("rst_err",     {31'b0, err},     32'd0);
    check("rst_req",     {31'b0, mem_req}, 32'd0);
    check("rst_we",      {31'b0, mem_we},  32'd0);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_addr",    {2'b0, mem_addr}, 32'h0);
    check("rst_be",      {28'b0, mem_be},  32'h0);
    check("rst_wdata",   mem_wdata,        32'h0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // SW 0x100, ack in the first ACCESS cycle
    issue(1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 3'b000);
    check("sw_req",   {31'b0, mem_req}, 32'd1);
    check("sw_we",    {31'b0, mem_we},  32'd1);
    check("sw_addr",  {2'b0, mem_addr}, 32'h40);
    check("sw_be",    {28'b0, mem_be},  32'hF);
    check("sw_wdata", mem_wdata,        32'hDEAD_BEEF);
    check("sw_done0", {31'b0, done},    32'd0);
    ack_cycle(32'h0);
    check("sw_done",  {31'b0, done},    32'd1);
    check("sw_err",   {31'b0, err},     32'd0);
    check("sw_req_off", {31'b0, mem_req}, 32'd0);
    step();
    check("sw_done_pulse", {31'b0, done}, 32'd0);
    check("sw_idle",  {31'b0, busy},    32'd0);

    // SB 0x103 be=1000
    issue(1'b1, 32'h0000_0103, 4'b1000, 32'h0000_00A5, 3'b000);
    check("sb_wdata", mem_wdata,        32'hA5A5_A5A5);
    check("sb_be",    {28'b0, mem_be},  32'h8);
    ack_cycle(32'h0);
    check("sb_done",  {31'b0, done},    32'd1);
    step();

    // SH 0x102 be=1100
    issue(1'b1, 32'h0000_0102, 4'b1100, 32'h0000_1234, 3'b000);
    check("sh_wdata", mem_wdata,        32'h1234_1234);
    check("sh_be",    {28'b0, mem_be},  32'hC);
    ack_cycle(32'h0);
    check("sh_done",  {31'b0, done},    32'd1);
    check("st_rdata_kept", rdata,       32'h0);
    step();

    // Loads of 0x80FF7F01
    issue(1'b0, 32'h0000_0203, 4'b0000, 32'h0, 3'b011);
    check("lb_be",    {28'b0, mem_be},  32'hF);
    check("lb_we",    {31'b0, mem_we},  32'd0);
    ack_cycle(32'h80FF_7F01);
    check("lb_rdata", rdata,            32'hFFFF_FF80);
    check("lb_done",  {31'b0, done},    32'd1);
    step();

    issue(1'b0, 32'h0000_0203, 4'b0000, 32'h0, 3'b100);
    ack_cycle(32'h80FF_7F01);
    check("lbu_rdata", rdata,           32'h0000_0080);
    step();

    issue(1'b0, 32'h0000_0202, 4'b0000, 32'h0, 3'b001);
    ack_cycle(32'h80FF_7F01);
    check("lh_rdata", rdata,            32'hFFFF_80FF);
    step();

    issue(1'b0, 32'h0000_0200, 4'b0000, 32'h0, 3'b010);
    ack_cycle(32'h80FF_7F01);
    check("lhu_rdata", rdata,           32'h0000_7F01);
    step();

    // LW with one wait cycle before the ack
    issue(1'b0, 32'h0000_0204, 4'b0000, 32'h0, 3'b000);
    check("lw_addr",  {2'b0, mem_addr}, 32'h81);
    step();
    check("lw_wait_done", {31'b0, done}, 32'd0);
    check("lw_wait_req",  {31'b0, mem_req}, 32'd1);
    ack_cycle(32'h80FF_7F01);
    check("lw_rdata", rdata,            32'h80FF_7F01);
    check("lw_done",  {31'b0, done},    32'd1);
    step();

    // Misaligned LW: error at T+1 with no memory access
    issue(1'b0, 32'h0000_0101, 4'b0000, 32'h0, 3'b000);
    check("mis_req",  {31'b0, mem_req}, 32'd0);
    check("mis_done", {31'b0, done},    32'd1);
    check("mis_err",  {31'b0, err},     32'd1);
    check("mis_rdata", rdata,           32'h80FF_7F01);
    step();
    check("mis_done_pulse", {31'b0, done}, 32'd0);

    // Store with illegal be=0101
    issue(1'b1, 32'h0000_0100, 4'b0101, 32'h1111_2222, 3'b000);
    check("ibe_req",  {31'b0, mem_req}, 32'd0);
    check("ibe_done", {31'b0, done},    32'd1);
    check("ibe_err",  {31'b0, err},     32'd1);
    check("ibe_rdata", rdata,           32'h80FF_7F01);
    step();

    // Timeout; a second start while busy must be ignored
    issue(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 3'b000);
    req_cycles = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (mem_req) req_cycles++;
      start = (i == 3);
      step();
    end
    start = 1'b0;
    check("tmo_cycles", req_cycles,       32'd16);
    check("tmo_done",  {31'b0, done},     32'd1);
    check("tmo_err",   {31'b0, err},      32'd1);
    check("tmo_req",   {31'b0, mem_req},  32'd0);
    check("tmo_rdata", rdata,             32'h80FF_7F01);
    step();
    check("tmo_idle",  {31'b0, busy},     32'd0);
    step();
    check("tmo_no_retry", {31'b0, mem_req}, 32'd0);

    // Ack arriving on the last timeout cycle wins
    issue(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 3'b000);
    for (int i = 0; i < 15; i++) step();
    check("last_req",  {31'b0, mem_req},  32'd1);
    ack_cycle(32'h0BAD_F00D);
    check("last_done", {31'b0, done},     32'd1);
    check("last_err",  {31'b0, err},      32'd0);
    check("last_rdata", rdata,            32'h0BAD_F00D);
    step();

    // Reset in the middle of ACCESS
    issue(1'b0, 32'h0000_0400, 4'b0000, 32'h0, 3'b000);
    check("mid_req",   {31'b0, mem_req},  32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'b0, mem_req}, 32'd0);
    check("mid_rst_busy",  {31'b0, busy},    32'd0);
    check("mid_rst_done",  {31'b0, done},    32'd0);
    check("mid_rst_rdata", rdata,            32'h0);
    @(negedge clk); rst_n = 1'b1;
    step();
    issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 3'b000);
    check("post_addr", {2'b0, mem_addr},  32'h4);
    ack_cycle(32'h1357_9BDF);
    check("post_done", {31'b0, done},     32'd1);
    check("post_err",  {31'b0, err},      32'd0);
    check("post_rdata", rdata,            32'h1357_9BDF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multicycle data-memory access controller. Sits directly downstream of the store byte-enable generator in the MEM stage.
- Consumes the ALU address, the byte enables and the rt store data, then runs one request/acknowledge transaction to data memory.
- Stores: replicates store data onto the correct byte lanes.
- Loads: selects and sign/zero-extends the addressed byte or halfword.
- Reports a one-cycle completion pulse to the main control FSM.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS without mem_ack before aborting with err.
- TCW, 5, width of the timeout counter (must satisfy 2^TCW > TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request from control FSM
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address (ALU out)
- be  in  4  store byte enables (from byte-enable generator)
- wdata  in  32  unaligned store data (rt)
- ld_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, illegal be, or timeout
- rdata  out  32  extended load result, held until the next done
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  30  word address, addr[31:2]
- mem_be  out  4  memory byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word
- mem_ack  in  1  memory acknowledge, sampled while mem_req = 1

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - busy, done, err, mem_req, mem_we all 0; rdata, mem_addr, mem_be, mem_wdata all 0; timeout counter = 0.
  - Takes effect immediately, including mid-transaction: mem_req drops without waiting for ack.
- IDLE:
  - start = 1 latches we, addr, be, wdata and ld_type into internal registers.
  - Legality checks (failure of any one → RESP with err = 1, no memory access):
    - store: be must be one of 1111, 1100, 0011, 0001, 0010, 0100, 1000.
    - LW requires addr[1:0] = 00.
    - LH/LHU require addr[0] = 0.
  - Legal request → ACCESS.
  - start is ignored in every state other than IDLE.
- ACCESS:
  - mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are driven from the latched registers and are stable for the whole state.
  - Loads drive mem_be = 1111.
  - On mem_ack = 1 at a clock edge:
    - a load captures the extracted value into rdata;
    - the state moves to RESP with err = 0.
  - Otherwise the counter increments. When the counter = TIMEOUT-1 and no ack arrives, the state moves to RESP with err = 1; rdata is unchanged.
  - Ack and timeout on the same edge: ack wins.
- RESP:
  - done = 1 for exactly one cycle; err is valid in the same cycle.
  - Counter clears; next state = IDLE.
  - mem_req = 0.
- Latency: start at edge T, mem_ack high during cycle T+1 → done high in cycle T+2. Each wait cycle adds one.
- Store lane replication, with type taken from the latched be:
  - 1111 → wdata.
  - 1100 or 0011 → {wdata[15:0], wdata[15:0]}.
  - one-hot → wdata[7:0] replicated ×4.
- Load extraction:
  - Byte lane = addr[1:0]; halfword = mem_rdata[31:16] if addr[1], else mem_rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Unknown ld_type (101–111) is treated as LW.
- rdata updates only on a successful load. Stores and errors leave rdata unchanged.
- done and err are registered outputs (no combinational path from inputs).

Test Plan:
- SW addr = 0x100, wdata = 0xDEADBEEF, be = 1111, mem_ack at T+1 → mem_addr = 0x40, mem_be = 1111, mem_wdata = 0xDEADBEEF, done at T+2, err = 0.
- SB addr = 0x103, wdata = 0x000000A5, be = 1000 → mem_wdata = 0xA5A5A5A5, mem_be = 1000; then SH addr = 0x102, be = 1100, wdata = 0x1234 → mem_wdata = 0x12341234.
- Loads of mem_rdata = 0x80FF7F01:
  - LB addr[1:0] = 11 → rdata = 0xFFFFFF80.
  - LBU addr[1:0] = 11 → 0x00000080.
  - LH addr = 0x...2 → 0xFFFF80FF.
  - LHU addr = 0x...0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Misaligned LW addr = 0x101, then store with be = 0101 → in each case mem_req never asserted; done with err = 1 at T+1; rdata unchanged.
- No ack for TIMEOUT = 16 cycles → mem_req high 16 cycles then 0, done + err = 1; a second start while busy is ignored (no extra transaction).
- rst_n pulled low while in ACCESS with mem_req = 1 → mem_req, busy and done go 0 immediately, rdata = 0; after release, a fresh LW completes normally.
